// File: rtl/alu_sweep_checker.sv
// Exhaustive stimulus/golden checker for the 4-bit ALU tile: sweeps all {op,b,a} vectors.
// Optional build macro CHK_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
//   state  | meaning
//   IDLE   | waiting for start after reset
//   SETTLE | current vector held on the ALU inputs
//   CHECK  | ALU result sampled and compared
//   DONE   | sweep finished, results held
module alu_sweep_checker #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [3:0]       drv_a,
    output logic [3:0]       drv_b,
    output logic [1:0]       drv_op,
    input  logic [3:0]       dut_res,
    input  logic             dut_cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic             fail_valid,
    output logic [9:0]       first_fail,
    output logic [9:0]       vec_idx
);

    localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SC_W-1:0] SC_LOAD = SC_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [SC_W-1:0]   settle_cnt;
    logic              start_ok;
    logic              mismatch;
    logic              last_vec;
    logic              stop_now;
    logic [4:0]        gold;
    logic [CNT_W-1:0]  err_nxt;
    logic [9:0]        vec_nxt;

    // Reference result for the vector currently on the ALU inputs: {cout, res}
    always_comb begin
        gold = 5'd0;
        case (drv_op)
            2'b00:   gold = {1'b0, drv_a} + {1'b0, drv_b};
            2'b01:   gold = {1'b0, drv_a} - {1'b0, drv_b};
            2'b10:   gold = {1'b0, drv_a & drv_b};
            default: gold = {1'b0, drv_a | drv_b};
        endcase
    end

    assign mismatch = ({dut_cout, dut_res} != gold);
    assign last_vec = (vec_idx == 10'h3FF);
    assign vec_nxt  = vec_idx + 10'd1;
    assign err_nxt  = (mismatch && (err_cnt != CNT_MAX)) ? err_cnt + 1'b1 : err_cnt;
    assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));

`ifdef CHK_STOP_ON_FAIL_EN
    assign stop_now = last_vec || mismatch;
`else
    assign stop_now = last_vec;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_ok) state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                busy = 1'b1;
                if (settle_cnt == '0) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                busy      = 1'b1;
                state_nxt = stop_now ? S_DONE : S_SETTLE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start_ok) state_nxt = S_SETTLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_idx    <= '0;
            drv_a      <= '0;
            drv_b      <= '0;
            drv_op     <= '0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
            pass       <= 1'b0;
            settle_cnt <= '0;
        end else if (start_ok) begin
            vec_idx    <= '0;
            drv_a      <= '0;
            drv_b      <= '0;
            drv_op     <= '0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
            pass       <= 1'b0;
            settle_cnt <= SC_LOAD;
        end else begin
            case (state)
                S_SETTLE: begin
                    if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
                end
                S_CHECK: begin
                    err_cnt <= err_nxt;
                    if (mismatch && !fail_valid) begin
                        fail_valid <= 1'b1;
                        first_fail <= vec_idx;
                    end
                    if (stop_now) begin
                        pass <= (err_nxt == '0);
                    end else begin
                        vec_idx                  <= vec_nxt;
                        {drv_op, drv_b, drv_a}   <= vec_nxt;
                        settle_cnt               <= SC_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sweep_checker.sv
// Self-checking bench for alu_sweep_checker: table-driven faulty ALU plus a cycle-indexed
// behavioural model of the expected checker outputs; honours CHK_STOP_ON_FAIL_EN.
module tb_alu_sweep_checker;

    localparam int SETTLE = 1;
    localparam int CW     = 4;
    localparam int PER    = SETTLE + 1;
    localparam int MAXE   = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          start;
    logic [3:0]    drv_a;
    logic [3:0]    drv_b;
    logic [1:0]    drv_op;
    logic [3:0]    dut_res;
    logic          dut_cout;
    logic          busy;
    logic          done;
    logic          pass;
    logic [CW-1:0] err_cnt;
    logic          fail_valid;
    logic [9:0]    first_fail;
    logic [9:0]    vec_idx;

    int checks = 0;
    int errors = 0;

    alu_sweep_checker #(.SETTLE_CYCLES(SETTLE), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .drv_a(drv_a), .drv_b(drv_b), .drv_op(drv_op),
        .dut_res(dut_res), .dut_cout(dut_cout),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .fail_valid(fail_valid), .first_fail(first_fail), .vec_idx(vec_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [4:0] golden(input int v);
        int a, b, op, r;
        logic c;
        a = v % 16;
        b = (v / 16) % 16;
        op = v / 256;
        c = 1'b0;
        case (op)
            0: begin r = (a + b) % 16; c = (a + b) > 15; end
            1: begin r = (a - b + 16) % 16; c = (a < b); end
            2: r = a & b;
            default: r = a | b;
        endcase
        return {c, r[3:0]};
    endfunction

    // ALU under test: golden result with per-vector XOR corruption
    logic [3:0] fx_res [1024];
    logic       fx_cout [1024];
    logic [9:0] alu_v;
    logic [4:0] alu_g;
    assign alu_v    = {drv_op, drv_b, drv_a};
    assign alu_g    = golden(int'(alu_v));
    assign dut_res  = alu_g[3:0] ^ fx_res[alu_v];
    assign dut_cout = alu_g[4] ^ fx_cout[alu_v];

    task automatic set_mode(input int mode);
        logic [4:0] g;
        int n, v;
        for (int i = 0; i < 1024; i++) begin
            fx_res[i]  = 4'h0;
            fx_cout[i] = 1'b0;
        end
        case (mode)
            1: for (int op = 0; op < 4; op++) begin
                fx_cout[op*256 + 15*16 + 15] = 1'b1;
                fx_cout[op*256 + 6*16 + 9]   = 1'b1;
                fx_cout[op*256 + 12*16 + 3]  = 1'b1;
            end
            2: for (int i = 0; i < 1024; i++) begin
                g = golden(i);
                fx_res[i] = g[3:0];
            end
            3: begin
                n = int'($urandom_range(1, 6));
                for (int k = 0; k < n; k++) begin
                    v = int'($urandom_range(0, 1023));
                    fx_res[v]  = 4'($urandom_range(0, 15));
                    fx_cout[v] = 1'($urandom_range(0, 1));
                    if (fx_res[v] == 4'h0 && !fx_cout[v]) fx_cout[v] = 1'b1;
                end
            end
            default: ;
        endcase
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: 0 idle, 1 sweeping, 2 finished; m_k = edges since the accepted start
    int m_state = 0;
    int m_k = 0;
    int m_last = 0;
    int m_total = 0;
    int m_fidx = -1;
    int pref [0:1024];
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_state = 0;
            m_k     = 0;
            m_fidx  = -1;
            for (int i = 0; i <= 1024; i++) pref[i] = 0;
            m_valid = 1'b1;
        end else if (start && m_state != 1) begin
            int cnt;
            cnt = 0;
            m_fidx = -1;
            for (int i = 0; i < 1024; i++) begin
                pref[i] = cnt;
                if (fx_res[i] != 4'h0 || fx_cout[i]) begin
                    cnt++;
                    if (m_fidx < 0) m_fidx = i;
                end
            end
            pref[1024] = cnt;
`ifdef CHK_STOP_ON_FAIL_EN
            m_last = (m_fidx >= 0) ? m_fidx : 1023;
`else
            m_last = 1023;
`endif
            m_total = (m_last + 1) * PER;
            m_state = 1;
            m_k     = 0;
        end else if (m_state == 1) begin
            m_k++;
            if (m_k == m_total) m_state = 2;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            int idx, comp, e_err;
            bit e_fv;
            idx  = 0;
            comp = 0;
            if (m_state == 1) begin
                idx  = m_k / PER;
                comp = idx;
            end else if (m_state == 2) begin
                idx  = m_last;
                comp = m_last + 1;
            end
            e_err = (pref[comp] > MAXE) ? MAXE : pref[comp];
            e_fv  = (m_fidx >= 0) && (m_fidx < comp);
            chk("busy", busy, m_state == 1);
            chk("done", done, m_state == 2);
            chk("pass", pass, (m_state == 2) && (pref[comp] == 0));
            chk("err_cnt", err_cnt, e_err);
            chk("fail_valid", fail_valid, e_fv);
            chk("first_fail", first_fail, e_fv ? m_fidx : 0);
            chk("vec_idx", vec_idx, idx);
            chk("drv", {drv_op, drv_b, drv_a}, idx);
        end
    end

    task automatic run_sweep(input int mode, input bit pulses, output int j);
        set_mode(mode);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        j = 0;
        while (!done && j < 5000) begin
            start = pulses && ($urandom_range(0, 7) == 0);
            @(negedge clk);
            j++;
        end
        start = 1'b0;
        chk("done_within_bound", done, 1);
    endtask

    initial begin
        int j;
        rst   = 1'b1;
        start = 1'b0;
        set_mode(0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err_cnt, 0);
        chk("reset_vec", vec_idx, 0);

        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("start_with_rst_ignored", busy, 0);

        run_sweep(0, 1'b0, j);
        chk("clean_done_cycle", j, 2048);
        chk("clean_pass", pass, 1);
        chk("clean_err", err_cnt, 0);
        chk("clean_fail_valid", fail_valid, 0);

        run_sweep(1, 1'b1, j);
        chk("trig_first_fail", first_fail, 10'h069);
        chk("trig_pass", pass, 0);
`ifdef CHK_STOP_ON_FAIL_EN
        chk("trig_done_cycle", j, 212);
        chk("trig_vec_idx", vec_idx, 10'h069);
        chk("trig_err", err_cnt, 1);
`else
        chk("trig_done_cycle", j, 2048);
        chk("trig_err", err_cnt, 12);
`endif

        run_sweep(2, 1'b0, j);
        chk("stuck_pass", pass, 0);
        chk("stuck_first_fail", first_fail, 10'h001);
`ifdef CHK_STOP_ON_FAIL_EN
        chk("stuck_err", err_cnt, 1);
        chk("stuck_done_cycle", j, 4);
`else
        chk("stuck_err_saturated", err_cnt, 15);
`endif

        repeat (3) run_sweep(3, 1'b1, j);

        set_mode(1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (499) @(negedge clk);
`ifndef CHK_STOP_ON_FAIL_EN
        chk("abort_busy_before", busy, 1);
        chk("abort_err_before", err_cnt, 2);
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_err", err_cnt, 0);
        chk("abort_vec", vec_idx, 0);
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
